trap_sequencer: RTL and testbench

Trap and return controller for the machine-mode CSR file. Sits between the writeback stage and the CSR stage. On an `ecall` or `mret` reported by writeback it:
- stalls the pipeline;
- sequences the required CSR writes (`mepc`, `mcause`) through the CSR file's single write port;
- issues one redirect-plus-flush pulse to fetch, targeting `mtvec` or `mepc`.

---
 rtl/trap_sequencer.sv | 125 ++++++++++++
 tb/tb_trap_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry / mret return controller.
// Sequences mepc and mcause writes through the CSR file's single write port,
// then issues one redirect+flush pulse to fetch. Holds the pipeline throughout.
module trap_sequencer #(
  parameter logic [11:0] CSR_ADDR_MEPC   = 12'h341,
  parameter logic [11:0] CSR_ADDR_MCAUSE = 12'h342
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret_req,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  input  logic        csr_ready,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [15:0] trap_count
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    REDIR_TRAP,
    REDIR_MRET
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;       // word address of the trapping instruction
  logic [31:0] cause_q, cause_d;
  logic [15:0] trap_count_q, trap_count_d;

  // Low address bits are forced to zero on every path, so they are never used.
  logic unused_low_bits;
  assign unused_low_bits = ^{trap_pc[1:0], csr_mtvec[1:0], csr_mepc[1:0]};

  // State and captured-trap registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      cause_q      <= '0;
      trap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cause_q      <= cause_d;
      trap_count_q <= trap_count_d;
    end
  end

  // Next-state logic and all strobes/data outputs, decoded from the current state.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    trap_count_d   = trap_count_q;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state_q)
      IDLE: begin
        stall = trap_req | mret_req;
        if (trap_req) begin
          pc_d    = trap_pc[31:2];
          cause_d = trap_cause;
          state_d = W_MEPC;
        end else if (mret_req) begin
          state_d = REDIR_MRET;
        end
      end
      W_MEPC: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = CSR_ADDR_MEPC;
        csr_wdata = {pc_q, 2'b00};
        if (csr_ready) state_d = W_MCAUSE;
      end
      W_MCAUSE: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = CSR_ADDR_MCAUSE;
        csr_wdata = cause_q;
        if (csr_ready) state_d = REDIR_TRAP;
      end
      REDIR_TRAP: begin
        stall          = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_mtvec[31:2], 2'b00};
        trap_count_d   = trap_count_q + 16'd1;
        state_d        = IDLE;
      end
      REDIR_MRET: begin
        stall          = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_mepc[31:2], 2'b00};
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The request term of stall is combinational on the inputs, so mask it
    // while reset is held to keep every output low during reset.
    if (reset) stall = 1'b0;
  end

  assign trap_count = trap_count_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap entry, back-pressure, mret,
// request priority, back-to-back requests, async reset and counter wrap.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_req;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_ready;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] trap_count;

  int n_cmp = 0;
  int n_err = 0;

  trap_sequencer #(
    .CSR_ADDR_MEPC  (12'h341),
    .CSR_ADDR_MCAUSE(12'h342)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trap_req      (trap_req),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .mret_req      (mret_req),
    .csr_mtvec     (csr_mtvec),
    .csr_mepc      (csr_mepc),
    .csr_we        (csr_we),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .csr_ready     (csr_ready),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap_count    (trap_count)
  );

  always #5 clk = ~clk;

  // Control bundle {stall, flush, redirect_valid, csr_we} and write bundle {waddr, wdata}.
  wire [3:0]  ctl = {stall, flush, redirect_valid, csr_we};
  wire [43:0] wr  = {csr_waddr, csr_wdata};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; trap_req = 1'b1; mret_req = 1'b1;
    trap_cause = 32'd11; trap_pc = 32'h104; csr_mtvec = 32'h201; csr_mepc = 32'h107;
    csr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", ctl, 4'b0000); end
    n_cmp++; if (wr !== 44'h0) begin n_err++; $display("FAIL reset_wr: got %h expected %h", wr, 44'h0); end
    n_cmp++; if ({redirect_pc, trap_count} !== 48'h0) begin n_err++; $display("FAIL reset_rpc_cnt: got %h expected %h", {redirect_pc, trap_count}, 48'h0); end
    trap_req = 1'b0; mret_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL reset_idle_ctl: got %b expected %b", ctl, 4'b0000); end
  endtask

  task automatic test_basic_trap;
    step();
    trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h0000_0104;
    csr_mtvec = 32'h0000_0201; csr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b1000) begin n_err++; $display("FAIL basic_c0_ctl: got %b expected %b", ctl, 4'b1000); end
    step();
    trap_req = 1'b0; trap_cause = 32'h0; trap_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b1001) begin n_err++; $display("FAIL basic_c1_ctl: got %b expected %b", ctl, 4'b1001); end
    n_cmp++; if (wr !== {12'h341, 32'h104}) begin n_err++; $display("FAIL basic_c1_wr: got %h expected %h", wr, {12'h341, 32'h104}); end
    step();
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b1001) begin n_err++; $display("FAIL basic_c2_ctl: got %b expected %b", ctl, 4'b1001); end
    n_cmp++; if (wr !== {12'h342, 32'd11}) begin n_err++; $display("FAIL basic_c2_wr: got %h expected %h", wr, {12'h342, 32'd11}); end
    step();
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b1110) begin n_err++; $display("FAIL basic_c3_ctl: got %b expected %b", ctl, 4'b1110); end
    n_cmp++; if (redirect_pc !== 32'h200) begin n_err++; $display("FAIL basic_c3_rpc: got %h expected %h", redirect_pc, 32'h200); end
    n_cmp++; if ({wr, trap_count} !== 60'h0) begin n_err++; $display("FAIL basic_c3_wr_cnt: got %h expected %h", {wr, trap_count}, 60'h0); end
    step();
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL basic_c4_ctl: got %b expected %b", ctl, 4'b0000); end
    n_cmp++; if ({redirect_pc, trap_count} !== {32'h0, 16'd1}) begin n_err++; $display("FAIL basic_c4_rpc_cnt: got %h expected %h", {redirect_pc, trap_count}, {32'h0, 16'd1}); end
  endtask

  task automatic test_backpressure;
    step();
    trap_req = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_ABCF;
    csr_mtvec = 32'h8000_0003; csr_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b1000) begin n_err++; $display("FAIL bp_c0_ctl: got %b expected %b", ctl, 4'b1000); end
    for (int c = 1; c <= 8; c++) begin
      step();
      trap_req = 1'b0;
      csr_ready = (c == 4 || c == 7);
      @(negedge clk);
      if (c <= 4) begin
        n_cmp++; if ({ctl, wr} !== {4'b1001, 12'h341, 32'h0000_ABCC}) begin n_err++; $display("FAIL bp_mepc_c%0d: got %h expected %h", c, {ctl, wr}, {4'b1001, 12'h341, 32'h0000_ABCC}); end
      end else if (c <= 7) begin
        n_cmp++; if ({ctl, wr} !== {4'b1001, 12'h342, 32'h8000_0007}) begin n_err++; $display("FAIL bp_mcause_c%0d: got %h expected %h", c, {ctl, wr}, {4'b1001, 12'h342, 32'h8000_0007}); end
      end else begin
        n_cmp++; if ({ctl, redirect_pc} !== {4'b1110, 32'h8000_0000}) begin n_err++; $display("FAIL bp_redir_c%0d: got %h expected %h", c, {ctl, redirect_pc}, {4'b1110, 32'h8000_0000}); end
      end
    end
    step();
    csr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ctl, trap_count} !== {4'b0000, 16'd2}) begin n_err++; $display("FAIL bp_end: got %h expected %h", {ctl, trap_count}, {4'b0000, 16'd2}); end
  endtask

  task automatic test_mret;
    step();
    mret_req = 1'b1; csr_mepc = 32'h0000_0107; csr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b1000) begin n_err++; $display("FAIL mret_c0_ctl: got %b expected %b", ctl, 4'b1000); end
    step();
    mret_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ctl, redirect_pc} !== {4'b1110, 32'h104}) begin n_err++; $display("FAIL mret_c1: got %h expected %h", {ctl, redirect_pc}, {4'b1110, 32'h104}); end
    n_cmp++; if (wr !== 44'h0) begin n_err++; $display("FAIL mret_c1_wr: got %h expected %h", wr, 44'h0); end
    step();
    @(negedge clk);
    n_cmp++; if ({ctl, redirect_pc, trap_count} !== {4'b0000, 32'h0, 16'd2}) begin n_err++; $display("FAIL mret_c2: got %h expected %h", {ctl, redirect_pc, trap_count}, {4'b0000, 32'h0, 16'd2}); end
  endtask

  task automatic test_simultaneous;
    step();
    trap_req = 1'b1; mret_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h2000_0010;
    csr_mtvec = 32'h0000_0300; csr_mepc = 32'h0000_0500; csr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b1000) begin n_err++; $display("FAIL sim_c0_ctl: got %b expected %b", ctl, 4'b1000); end
    step();
    trap_req = 1'b0; mret_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ctl, wr} !== {4'b1001, 12'h341, 32'h2000_0010}) begin n_err++; $display("FAIL sim_c1: got %h expected %h", {ctl, wr}, {4'b1001, 12'h341, 32'h2000_0010}); end
    step();
    mret_req = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ctl, wr} !== {4'b1001, 12'h342, 32'd11}) begin n_err++; $display("FAIL sim_c2: got %h expected %h", {ctl, wr}, {4'b1001, 12'h342, 32'd11}); end
    step();
    mret_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ctl, redirect_pc} !== {4'b1110, 32'h300}) begin n_err++; $display("FAIL sim_c3: got %h expected %h", {ctl, redirect_pc}, {4'b1110, 32'h300}); end
    for (int c = 4; c <= 5; c++) begin
      step();
      @(negedge clk);
      n_cmp++; if ({ctl, trap_count} !== {4'b0000, 16'd3}) begin n_err++; $display("FAIL sim_c%0d: got %h expected %h", c, {ctl, trap_count}, {4'b0000, 16'd3}); end
    end
  endtask

  task automatic test_back_to_back;
    step();
    trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h0000_0040;
    csr_mtvec = 32'h0000_0100; csr_mepc = 32'h0000_0044; csr_ready = 1'b1;
    step();
    trap_req = 1'b0;
    step();
    step();
    @(negedge clk);
    n_cmp++; if ({ctl, redirect_pc} !== {4'b1110, 32'h100}) begin n_err++; $display("FAIL b2b_trap_redir: got %h expected %h", {ctl, redirect_pc}, {4'b1110, 32'h100}); end
    step();
    mret_req = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ctl, trap_count} !== {4'b1000, 16'd4}) begin n_err++; $display("FAIL b2b_accept: got %h expected %h", {ctl, trap_count}, {4'b1000, 16'd4}); end
    step();
    mret_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ctl, redirect_pc} !== {4'b1110, 32'h44}) begin n_err++; $display("FAIL b2b_mret_redir: got %h expected %h", {ctl, redirect_pc}, {4'b1110, 32'h44}); end
    step();
    @(negedge clk);
    n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL b2b_idle: got %b expected %b", ctl, 4'b0000); end
  endtask

  task automatic test_reset_mid;
    step();
    trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h0000_0800;
    csr_mtvec = 32'h0000_0900; csr_ready = 1'b1;
    step();
    trap_req = 1'b0;
    step();
    @(negedge clk);
    n_cmp++; if ({ctl, wr} !== {4'b1001, 12'h342, 32'd11}) begin n_err++; $display("FAIL rmid_pre: got %h expected %h", {ctl, wr}, {4'b1001, 12'h342, 32'd11}); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({ctl, wr, redirect_pc, trap_count} !== 96'h0) begin n_err++; $display("FAIL rmid_async: got %h expected %h", {ctl, wr, redirect_pc, trap_count}, 96'h0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      n_cmp++; if ({ctl, redirect_pc, trap_count} !== 52'h0) begin n_err++; $display("FAIL rmid_after_c%0d: got %h expected %h", c, {ctl, redirect_pc, trap_count}, 52'h0); end
    end
  endtask

  task automatic run_trap;
    step();
    trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h0000_1000;
    csr_mtvec = 32'h0000_2000; csr_ready = 1'b1;
    step();
    trap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reaching 0xFFFE by real traps would cost ~262k cycles, so the counter
  // register is preloaded and the last three increments are exercised for real.
  task automatic test_counter_wrap;
    step();
    run_trap();
    @(negedge clk);
    n_cmp++; if (trap_count !== 16'd1) begin n_err++; $display("FAIL wrap_first: got %h expected %h", trap_count, 16'd1); end
    force dut.trap_count_q = 16'hFFFE;
    #1;
    release dut.trap_count_q;
    run_trap();
    @(negedge clk);
    n_cmp++; if (trap_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %h expected %h", trap_count, 16'hFFFF); end
    run_trap();
    @(negedge clk);
    n_cmp++; if (trap_count !== 16'h0000) begin n_err++; $display("FAIL wrap_0000: got %h expected %h", trap_count, 16'h0000); end
    run_trap();
    @(negedge clk);
    n_cmp++; if (trap_count !== 16'h0001) begin n_err++; $display("FAIL wrap_0001: got %h expected %h", trap_count, 16'h0001); end
  endtask

  initial begin
    test_reset();
    test_basic_trap();
    test_backpressure();
    test_mret();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
